// File: rtl/record_play_sequencer.sv
// record_play_sequencer: record/playback/delete control FSM issuing single-cycle song-memory commands.
// Define PLAY_LOOP_EN to repeat the selected slot until btn_stop instead of ending playback.
module record_play_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int SLOT_BITS   = 4,
    parameter int MAX_SLOT    = 8,
    parameter int PRE_WRITTEN = 5,
    parameter int DUR_BITS    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  btn_record,
    input  logic                  btn_play,
    input  logic                  btn_stop,
    input  logic                  btn_save,
    input  logic                  btn_discard,
    input  logic                  btn_delete,
    input  logic [SLOT_BITS-1:0]  sel_in,
    input  logic                  key_valid,
    input  logic [DATA_WIDTH-1:0] key_note,
    input  logic                  mem_full,
    input  logic [MAX_SLOT:0]     mem_unit_status,
    input  logic                  mem_output_ready,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DUR_BITS-1:0]   mem_duration,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic                  mem_read_rst,
    output logic                  mem_save,
    output logic                  mem_discard,
    output logic                  mem_delete,
    output logic [SLOT_BITS-1:0]  mem_select,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [DATA_WIDTH-1:0] play_note,
    output logic                  play_valid,
    output logic [2:0]            state,
    output logic                  err
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REC        = 3'd1,
        CONFIRM    = 3'd2,
        PLAY_START = 3'd3,
        PLAY       = 3'd4,
        DEL        = 3'd5
    } state_t;

    localparam logic [SLOT_BITS-1:0] LAST_SEL = SLOT_BITS'(MAX_SLOT);
    localparam logic [SLOT_BITS-1:0] USER_SEL = SLOT_BITS'(PRE_WRITTEN);

    state_t st, st_d;
    logic [DUR_BITS-1:0]   cnt, cnt_d, dur_eff;
    logic [DUR_BITS:0]     cnt_inc;
    logic [SLOT_BITS-1:0]  sel_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic wait_q, wait_d, wr_d, rd_d, rrst_d, save_d, disc_d, del_d, err_d;
    logic b_save, b_disc, b_del, b_play, b_rec, sel_ok, term;

    // one-hot priority decode: stop > save > discard > delete > play > record
    assign b_save = btn_save & ~btn_stop;
    assign b_disc = btn_discard & ~btn_save & ~btn_stop;
    assign b_del  = btn_delete & ~btn_discard & ~btn_save & ~btn_stop;
    assign b_play = btn_play & ~btn_delete & ~btn_discard & ~btn_save & ~btn_stop;
    assign b_rec  = btn_record & ~btn_play & ~btn_delete & ~btn_discard & ~btn_save & ~btn_stop;

    assign sel_ok  = (sel_in <= LAST_SEL) && mem_unit_status[sel_in];
    assign cnt_inc = {1'b0, cnt} + {{DUR_BITS{1'b0}}, 1'b1};
    assign dur_eff = (mem_duration == '0) ? {{(DUR_BITS-1){1'b0}}, 1'b1} : mem_duration;
    assign term    = cnt_inc >= {1'b0, dur_eff};

    assign state      = st;
    assign play_valid = (st == PLAY) && mem_output_ready;
    assign play_note  = play_valid ? mem_data : '0;

    always_comb begin
        st_d    = st;
        cnt_d   = cnt;
        wait_d  = 1'b0;
        sel_d   = mem_select;
        wdata_d = mem_data_in;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        rrst_d  = 1'b0;
        save_d  = 1'b0;
        disc_d  = 1'b0;
        del_d   = 1'b0;
        err_d   = 1'b0;
        case (st)
            IDLE: begin
                if (b_rec) begin
                    err_d = mem_full;
                    st_d  = mem_full ? IDLE : REC;
                end else if (b_play) begin
                    sel_d  = sel_in;
                    err_d  = !sel_ok;
                    rrst_d = sel_ok;
                    st_d   = sel_ok ? PLAY_START : IDLE;
                end else if (b_del) begin
                    sel_d = sel_in;
                    err_d = !sel_ok || (sel_in < USER_SEL);
                    del_d = !err_d;
                    st_d  = err_d ? IDLE : DEL;
                end
            end
            REC: begin
                if (btn_stop) st_d = CONFIRM;
                else if (tick) begin
                    wr_d    = 1'b1;
                    wdata_d = key_valid ? key_note : '0;
                end
            end
            CONFIRM: begin
                save_d = b_save;
                disc_d = b_disc;
                st_d   = (b_save || b_disc) ? IDLE : CONFIRM;
            end
            PLAY_START: begin
                cnt_d = '0;
                st_d  = PLAY;
            end
            PLAY: begin
                if (btn_stop) st_d = IDLE;
                else if (wait_q) st_d = PLAY;
                else if (!mem_output_ready) begin
`ifdef PLAY_LOOP_EN
                    st_d   = PLAY_START;
                    rrst_d = 1'b1;
`else
                    st_d = IDLE;
`endif
                end else if (tick) begin
                    rd_d   = term;
                    wait_d = term;
                    cnt_d  = term ? '0 : cnt_inc[DUR_BITS-1:0];
                end
            end
            DEL: st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            cnt          <= '0;
            wait_q       <= 1'b0;
            mem_select   <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_read_rst <= 1'b0;
            mem_save     <= 1'b0;
            mem_discard  <= 1'b0;
            mem_delete   <= 1'b0;
            err          <= 1'b0;
        end else begin
            st           <= st_d;
            cnt          <= cnt_d;
            wait_q       <= wait_d;
            mem_select   <= sel_d;
            mem_data_in  <= wdata_d;
            mem_write_en <= wr_d;
            mem_read_en  <= rd_d;
            mem_read_rst <= rrst_d;
            mem_save     <= save_d;
            mem_discard  <= disc_d;
            mem_delete   <= del_d;
            err          <= err_d;
        end
    end
endmodule

// File: tb/tb_record_play_sequencer.sv
// tb_record_play_sequencer: directed + randomized checks with a behavioural song-memory responder.
module tb_record_play_sequencer;
    logic clk = 0, rst_n = 0, tick = 0;
    logic btn_record = 0, btn_play = 0, btn_stop = 0, btn_save = 0, btn_discard = 0, btn_delete = 0;
    logic [3:0] sel_in = 0;
    logic key_valid = 0;
    logic [7:0] key_note = 0;
    logic mem_full = 0;
    logic [8:0] mem_unit_status = 0;
    logic mem_output_ready;
    logic [7:0] mem_data;
    logic [9:0] mem_duration;
    logic mem_write_en, mem_read_en, mem_read_rst, mem_save, mem_discard, mem_delete;
    logic [3:0] mem_select;
    logic [7:0] mem_data_in, play_note;
    logic play_valid, err;
    logic [2:0] state;
    logic [30:0] outs;

    int total = 0, bad = 0;
    int n_wr = 0, n_save = 0, n_disc = 0, n_del = 0, n_overlap = 0;
    int exp_wr = 0, exp_del = 0;
    logic [7:0] m_note[16];
    logic [9:0] m_dur[16];
    int m_len = 0, rd_ptr = 0;

    record_play_sequencer dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .btn_record(btn_record), .btn_play(btn_play), .btn_stop(btn_stop),
        .btn_save(btn_save), .btn_discard(btn_discard), .btn_delete(btn_delete),
        .sel_in(sel_in), .key_valid(key_valid), .key_note(key_note),
        .mem_full(mem_full), .mem_unit_status(mem_unit_status),
        .mem_output_ready(mem_output_ready), .mem_data(mem_data), .mem_duration(mem_duration),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_read_rst(mem_read_rst),
        .mem_save(mem_save), .mem_discard(mem_discard), .mem_delete(mem_delete),
        .mem_select(mem_select), .mem_data_in(mem_data_in),
        .play_note(play_note), .play_valid(play_valid), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    // song memory: read pointer reset/advanced by the command pulses
    always @(posedge clk) begin
        if (mem_read_rst) rd_ptr <= 0;
        else if (mem_read_en) rd_ptr <= rd_ptr + 1;
    end
    assign mem_output_ready = rd_ptr < m_len;
    assign mem_data     = mem_output_ready ? m_note[rd_ptr[3:0]] : 8'h0;
    assign mem_duration = mem_output_ready ? m_dur[rd_ptr[3:0]] : 10'h0;

    assign outs = {mem_write_en, mem_read_en, mem_read_rst, mem_save, mem_discard, mem_delete,
                   mem_select, mem_data_in, play_note, play_valid, state, err};

    always @(negedge clk) begin
        n_wr   += int'(mem_write_en);
        n_save += int'(mem_save);
        n_disc += int'(mem_discard);
        n_del  += int'(mem_delete);
        if ($countones({mem_write_en, mem_read_en, mem_read_rst, mem_save, mem_discard, mem_delete}) > 1)
            n_overlap++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rec_tick(input logic v, input logic [7:0] n);
        key_valid = v; key_note = n; tick = 1;
        cyc();
        tick = 0;
        chk("rec_wr", {31'b0, mem_write_en}, 1);
        chk("rec_data", {24'b0, mem_data_in}, {24'b0, v ? n : 8'h00});
        exp_wr++;
        cyc();
        chk("rec_wr_width", {31'b0, mem_write_en}, 0);
    endtask

    task automatic start_play(input logic [3:0] s);
        sel_in = s; btn_play = 1;
        cyc();
        btn_play = 0;
        chk("play_rrst", {31'b0, mem_read_rst}, 1);
        chk("play_start_state", {29'b0, state}, 3);
        chk("play_sel", {28'b0, mem_select}, {28'b0, s});
        cyc();
        chk("play_rrst_width", {31'b0, mem_read_rst}, 0);
        chk("play_state", {29'b0, state}, 4);
        chk("play_valid_rise", {31'b0, play_valid}, 1);
    endtask

    // each entry sounds for max(duration,1) ticks; its last tick requests the next entry
    task automatic run_entries();
        for (int e = 0; e < m_len; e++) begin
            int d = (m_dur[e] == 0) ? 1 : int'(m_dur[e]);
            for (int t = 0; t < d; t++) begin
                tick = 1;
                chk("note_valid", {31'b0, play_valid}, 1);
                chk("note", {24'b0, play_note}, {24'b0, m_note[e]});
                cyc();
                tick = 0;
                chk("step_rd", {31'b0, mem_read_en}, {31'b0, t == d - 1});
                cyc();
                cyc();
            end
        end
    endtask

    task automatic end_play();
        for (int i = 0; i < 8 && state == 3'd4; i++) cyc();
`ifdef PLAY_LOOP_EN
        chk("loop_state", {29'b0, state}, 3);
        chk("loop_rrst", {31'b0, mem_read_rst}, 1);
        cyc();
        chk("loop_replay", {24'b0, play_note}, {24'b0, m_note[0]});
        btn_stop = 1;
        cyc();
        btn_stop = 0;
`endif
        chk("end_state", {29'b0, state}, 0);
        chk("end_valid", {31'b0, play_valid}, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_note[i] = 0;
            m_dur[i] = 0;
        end
        repeat (3) cyc();
        chk("reset_outs", {1'b0, outs}, 0);
        rst_n = 1;
        cyc();

        // record with save; the tick coinciding with btn_record is not written
        btn_record = 1; tick = 1;
        cyc();
        btn_record = 0; tick = 0;
        chk("rec_enter", {29'b0, state}, 1);
        chk("rec_no_early_wr", {31'b0, mem_write_en}, 0);
        rec_tick(1, 8'h12);
        rec_tick(0, 8'h77);
        rec_tick(1, 8'h34);
        begin
            int n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) rec_tick(1'($urandom), 8'($urandom));
        end
        btn_stop = 1; tick = 1;
        cyc();
        btn_stop = 0; tick = 0;
        chk("stop_state", {29'b0, state}, 2);
        chk("stop_tick_nowr", {31'b0, mem_write_en}, 0);
        btn_save = 1;
        cyc();
        btn_save = 0;
        chk("save_pulse", {31'b0, mem_save}, 1);
        chk("save_state", {29'b0, state}, 0);
        cyc();
        chk("save_width", {31'b0, mem_save}, 0);

        // record refused while memory is full
        mem_full = 1; btn_record = 1;
        cyc();
        btn_record = 0; mem_full = 0;
        chk("full_err", {31'b0, err}, 1);
        chk("full_state", {29'b0, state}, 0);
        cyc();
        chk("err_width", {31'b0, err}, 0);

        // record then discard; stop+save together in CONFIRM does nothing
        btn_record = 1;
        cyc();
        btn_record = 0;
        rec_tick(1, 8'($urandom));
        btn_stop = 1;
        cyc();
        btn_stop = 0;
        btn_stop = 1; btn_save = 1;
        cyc();
        btn_stop = 0; btn_save = 0;
        chk("confirm_save_ignored", {31'b0, mem_save}, 0);
        chk("confirm_hold", {29'b0, state}, 2);
        btn_record = 1; btn_play = 1;
        cyc();
        btn_record = 0; btn_play = 0;
        chk("confirm_other_ignored", {29'b0, state}, 2);
        btn_discard = 1;
        cyc();
        btn_discard = 0;
        chk("discard_pulse", {31'b0, mem_discard}, 1);
        chk("discard_state", {29'b0, state}, 0);
        cyc();
        chk("discard_width", {31'b0, mem_discard}, 0);

        // directed playback of slot 2
        mem_unit_status = 9'b0_0000_0100;
        m_note[0] = 8'h20; m_dur[0] = 10'd2;
        m_note[1] = 8'h21; m_dur[1] = 10'd0;
        m_len = 2;
        start_play(4'd2);
        run_entries();
        end_play();

        // randomized playback
        repeat (3) begin
            logic [3:0] s;
            s = 4'($urandom_range(0, 8));
            mem_unit_status = 9'b1 << s;
            m_len = $urandom_range(1, 3);
            for (int i = 0; i < m_len; i++) begin
                m_note[i] = 8'($urandom);
                m_dur[i] = 10'($urandom_range(0, 3));
            end
            start_play(s);
            run_entries();
            end_play();
        end

        // play rejections
        mem_unit_status = 9'h1FB; sel_in = 4'd2; btn_play = 1;
        cyc();
        btn_play = 0;
        chk("play_empty_err", {31'b0, err}, 1);
        chk("play_empty_state", {29'b0, state}, 0);
        chk("play_empty_sel", {28'b0, mem_select}, 2);
        chk("play_empty_rrst", {31'b0, mem_read_rst}, 0);
        mem_unit_status = 9'h1FF; sel_in = 4'd12; btn_play = 1;
        cyc();
        btn_play = 0;
        chk("play_range_err", {31'b0, err}, 1);
        chk("play_range_state", {29'b0, state}, 0);

        // delete: built-in slot refused, user slot accepted, empty slot refused
        sel_in = 4'd3; btn_delete = 1;
        cyc();
        btn_delete = 0;
        chk("del_builtin_err", {31'b0, err}, 1);
        chk("del_builtin_nodel", {31'b0, mem_delete}, 0);
        cyc();
        chk("del_builtin_nodel2", {31'b0, mem_delete}, 0);
        sel_in = 4'd6; btn_delete = 1;
        cyc();
        btn_delete = 0;
        exp_del++;
        chk("del_pulse", {31'b0, mem_delete}, 1);
        chk("del_state", {29'b0, state}, 5);
        chk("del_sel", {28'b0, mem_select}, 6);
        chk("del_noerr", {31'b0, err}, 0);
        cyc();
        chk("del_width", {31'b0, mem_delete}, 0);
        chk("del_back_idle", {29'b0, state}, 0);
        mem_unit_status = 9'h17F; sel_in = 4'd7; btn_delete = 1;
        cyc();
        btn_delete = 0;
        chk("del_empty_err", {31'b0, err}, 1);

        // delete outranks play and record
        mem_unit_status = 9'h1FF; sel_in = 4'd8;
        btn_delete = 1; btn_play = 1; btn_record = 1;
        cyc();
        btn_delete = 0; btn_play = 0; btn_record = 0;
        exp_del++;
        chk("prio_state", {29'b0, state}, 5);
        chk("prio_del", {31'b0, mem_delete}, 1);
        cyc();

        // stop mid-entry
        mem_unit_status = 9'b0_0010_0000;
        m_note[0] = 8'($urandom); m_dur[0] = 10'd5; m_len = 1;
        start_play(4'd5);
        repeat (2) begin
            tick = 1;
            cyc();
            tick = 0;
            cyc();
        end
        btn_stop = 1; tick = 1;
        cyc();
        btn_stop = 0; tick = 0;
        chk("stop_play_state", {29'b0, state}, 0);
        chk("stop_play_valid", {31'b0, play_valid}, 0);
        cyc();
        chk("stop_play_nord", {31'b0, mem_read_en}, 0);

        // asynchronous reset mid-play
        start_play(4'd5);
        tick = 1;
        cyc();
        tick = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst_outs", {1'b0, outs}, 0);
        cyc();
        rst_n = 1;
        cyc();
        chk("post_rst_state", {29'b0, state}, 0);

        chk("wr_count", n_wr, exp_wr);
        chk("save_count", n_save, 1);
        chk("discard_count", n_disc, 1);
        chk("delete_count", n_del, exp_del);
        chk("no_overlap", n_overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/record_play_sequencer.md
# record_play_sequencer

Control FSM that sits between the organ's front-panel buttons and the nine-slot song memory. It sequences recording (per-tick note writes, then save or discard), playback of a selected slot (duration-timed note stepping), and deletion of user slots. It also enforces the memory's slot rules, so the memory sees only legal, single-cycle command pulses.

## Interface
- DATA_WIDTH, 8, note code width; 0 means rest
- SLOT_BITS, 4, slot index width
- MAX_SLOT, 8, highest slot index
- PRE_WRITTEN, 5, slots 0..PRE_WRITTEN-1 are read-only built-in songs
- DUR_BITS, 10, per-entry duration width, in ticks

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle time-base strobe (1/16 beat)
- btn_record, btn_play, btn_stop, btn_save, btn_discard, btn_delete  in  1 each  debounced one-cycle pulses
- sel_in  in  SLOT_BITS  user slot selection
- key_valid  in  1  a key is held
- key_note  in  DATA_WIDTH  held key's note code
- mem_full  in  1  memory full flag
- mem_unit_status  in  MAX_SLOT+1  per-slot occupied bits
- mem_output_ready  in  1  current read entry valid
- mem_data  in  DATA_WIDTH  current read note
- mem_duration  in  DUR_BITS  current read entry duration
- mem_write_en, mem_read_en, mem_read_rst, mem_save, mem_discard, mem_delete  out  1 each  memory command pulses
- mem_select  out  SLOT_BITS  slot addressed by read/delete
- mem_data_in  out  DATA_WIDTH  note written when recording
- play_note  out  DATA_WIDTH  note to the tone generator
- play_valid  out  1  play_note is valid
- state  out  3  encoded state, for the display
- err  out  1  one-cycle pulse on a rejected command

## Operation
- States (code): IDLE 0, REC 1, CONFIRM 2, PLAY_START 3, PLAY 4, DEL 5.
- Button priority when pulses coincide: stop > save > discard > delete > play > record. A lower-priority button is ignored.
- IDLE
  - btn_record: if mem_full, pulse err and stay. Otherwise go to REC.
  - btn_play: latch sel_in into mem_select. If sel_in > MAX_SLOT or mem_unit_status[sel_in]=0, pulse err. Otherwise go to PLAY_START.
  - btn_delete: latch mem_select. If sel_in < PRE_WRITTEN, sel_in > MAX_SLOT, or the status bit is 0, pulse err. Otherwise go to DEL.
- REC
  - On each tick, pulse mem_write_en for one cycle with mem_data_in = key_valid ? key_note : 0.
  - btn_stop goes to CONFIRM.
- CONFIRM
  - btn_save: pulse mem_save for one cycle, then IDLE.
  - btn_discard: pulse mem_discard for one cycle, then IDLE.
  - All other buttons are ignored.
- PLAY_START: pulse mem_read_rst for one cycle, then go to PLAY.
- PLAY
  - If mem_output_ready=0, end playback: go to IDLE, play_valid=0.
  - Otherwise play_valid=1 and play_note=mem_data. A DUR_BITS tick counter runs from 0.
  - When counter+1 ≥ max(mem_duration,1) on a tick: pulse mem_read_en for one cycle, clear the counter, and wait one cycle before resampling mem_output_ready.
  - btn_stop goes to IDLE immediately.
- DEL: pulse mem_delete for one cycle, then IDLE.
- mem_select is held stable throughout PLAY_START, PLAY and DEL.

## Timing
- Reset values: all outputs 0, state=IDLE, counters 0. The reset is asynchronous, takes effect mid-operation, and issues no save or discard.
- All command pulses are registered, exactly one cycle wide, and never overlap.
- IDLE→REC: the first write occurs on the first tick strictly after entry.
- A tick in the same cycle as btn_stop in REC is not written.
- mem_read_rst is asserted in the cycle after btn_play is accepted.
- play_valid rises 2 cycles after btn_play.
- Step latency: mem_read_en asserts in the cycle after the terminating tick.
- err fires in the cycle after the rejected button.

## Configuration
- PLAY_LOOP_EN defined: at end of playback (mem_output_ready=0), return to PLAY_START and repeat the slot until btn_stop.
- PLAY_LOOP_EN undefined: end of playback returns to IDLE.

## Test plan
- Reset, btn_record, 3 ticks with key_note=0x12, then 0x00, 0x34 → three mem_write_en pulses carrying 0x12, 0x00, 0x34; btn_stop, btn_save → single mem_save pulse, state=0.
- btn_play with sel_in=2, status bit set, entries (0x20,dur 2),(0x21,dur 0) → mem_read_rst at +1; play_note 0x20 for 2 ticks; 0x21 for 1 tick; play_valid drops when mem_output_ready=0.
- btn_delete with sel_in=3 → err, no mem_delete; with sel_in=6 and status set → one mem_delete, mem_select=6.
- btn_record with mem_full=1 → err, state stays 0. btn_stop and btn_save in the same cycle in CONFIRM → save is ignored; the later btn_discard gives one mem_discard.
- rst_n low mid-PLAY → all outputs 0 asynchronously, state=0.
- With PLAY_LOOP_EN: end of slot → mem_read_rst re-pulses and playback repeats until btn_stop.
